// File: rtl/burst_mem_responder.sv
// -----------------------------------------------------------------------------
// burst_mem_responder
//
// Memory-side responder for a cacheline burst port. Each transaction moves one
// 256-bit line as four 64-bit beats, lowest beat first. The first beat comes a
// fixed LATENCY wait cycles after the request is accepted. Line storage is
// internal. Misuse of the handshake sets a sticky error flag.
//
// Parameters
//   DEPTH_LINES : number of 256-bit lines stored (power of 2, >= 2)
//   LATENCY     : wait cycles between acceptance and first beat (>= 1)
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   pmem_read    in   1   line read request
//   pmem_write   in   1   line write request
//   pmem_address in  32   line address (bits [4:0] ignored, upper bits alias)
//   pmem_wdata   in  64   write beat, sampled on each edge with pmem_resp=1
//   pmem_rdata   out 64   read beat, valid while pmem_resp=1 in a read burst
//   pmem_resp    out  1   high for four consecutive cycles per transaction
//   err          out  1   sticky protocol-violation flag
// -----------------------------------------------------------------------------
module burst_mem_responder #(
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_address,
   input  logic [63:0] pmem_wdata,
   output logic [63:0] pmem_rdata,
   output logic        pmem_resp,
   output logic        err
);

   localparam int LW = $clog2(DEPTH_LINES);          // line index width
   localparam int AW = LW + 2;                        // word address width
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST,
      ST_DONE
   } state_t;

   state_t          state_q;
   logic [LW-1:0]   line_q;
   logic            op_wr_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      beat_q;
   logic            resp_q;
   logic            err_q;

   logic [63:0]     mem_q [0:DEPTH_LINES*4-1];
   logic [63:0]     rd_word_q;
   logic [1:0]      next_beat_d;
   logic [AW-1:0]   rd_addr_d;
   logic [AW-1:0]   wr_addr_d;
   logic            wr_en_d;
   logic            busy_d;
   logic            viol_d;

   // Address bits outside the line index are intentionally ignored.
   logic            unused_addr;
   assign unused_addr = ^{pmem_address[31:5+LW], pmem_address[4:0]};

   // Protocol checks while a transaction is in flight: the latched request
   // must stay asserted and the opposite request must stay low.
   assign busy_d = (state_q == ST_WAIT) || (state_q == ST_BURST);
   assign viol_d = busy_d &&
                   (op_wr_q ? (!pmem_write || pmem_read)
                            : (!pmem_read  || pmem_write));

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         line_q  <= '0;
         op_wr_q <= 1'b0;
         cnt_q   <= '0;
         beat_q  <= 2'd0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pmem_read && pmem_write) begin
                  err_q <= 1'b1;
               end else if (pmem_read || pmem_write) begin
                  line_q  <= pmem_address[5 +: LW];
                  op_wr_q <= pmem_write;
                  cnt_q   <= CW'(LATENCY - 1);
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_BURST;
                  beat_q  <= 2'd0;
                  resp_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_BURST: begin
               beat_q <= beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_q <= ST_DONE;
                  resp_q  <= 1'b0;
               end
            end
            // Requests are deliberately not sampled here, giving the
            // initiator one cycle to drop its request after the last beat.
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         if (viol_d) begin
            err_q <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Line storage
   // The read port is registered, so it is addressed one beat ahead: the last
   // WAIT cycle fetches beat 0 and each BURST cycle fetches the following beat.
   // Nothing is written during a read burst, so the look-ahead is safe.
   // -------------------------------------------------------------------------
   assign next_beat_d = beat_q + 2'd1;
   assign rd_addr_d   = {line_q, (state_q == ST_BURST) ? next_beat_d : 2'd0};
   assign wr_addr_d   = {line_q, beat_q};
   assign wr_en_d     = (state_q == ST_BURST) && op_wr_q;

   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem_q[wr_addr_d] <= pmem_wdata;
      end
      rd_word_q <= mem_q[rd_addr_d];
   end

   // resp_q is cleared asynchronously by rst, which also forces rdata to zero.
   assign pmem_resp  = resp_q;
   assign pmem_rdata = (resp_q && !op_wr_q) ? rd_word_q : 64'd0;
   assign err        = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_burst_mem_responder
//
// Directed bench for burst_mem_responder. Two instances share the stimulus:
// dut (LATENCY=10) carries the main table of line transactions and the
// corner sequences, dut1 (LATENCY=1) is observed only for back-to-back timing.
// -----------------------------------------------------------------------------
module tb_burst_mem_responder;

   localparam int L = 10;

   localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] C0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] C1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] C2 = 64'h0000_0000_0000_0000;
   localparam logic [63:0] C3 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [63:0] pmem_wdata;
   logic [63:0] rdata, rdata1;
   logic        resp, resp1;
   logic        err, err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (rdata),
      .pmem_resp    (resp),
      .err          (err)
   );

   burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(1)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (rdata1),
      .pmem_resp    (resp1),
      .err          (err1)
   );

   typedef struct {
      logic            wr;
      logic [31:0]     addr;
      logic [3:0][63:0] data;   // write beats, or expected read beats
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 32'd0;
      pmem_wdata   = 64'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called at #1 into an IDLE cycle (cycle 0). Returns at #1 into the IDLE
   // cycle after DONE, ready for the next request.
   task automatic do_txn(input logic wr, input logic [31:0] addr,
                         input logic [3:0][63:0] data, input int id);
      int  b;
      logic in_burst;
      pmem_read    = ~wr;
      pmem_write   = wr;
      pmem_address = addr;
      for (int c = 1; c <= L + 5; c++) begin
         @(posedge clk); #1;
         in_burst = (c >= L + 1) && (c <= L + 4);
         chk($sformatf("txn%0d resp c%0d", id, c), 64'(resp), 64'(in_burst));
         if (in_burst) begin
            b = c - L - 1;
            if (wr) begin
               pmem_wdata = data[b];
               chk($sformatf("txn%0d wr rdata c%0d", id, c), rdata, 64'd0);
            end else begin
               chk($sformatf("txn%0d rdata beat%0d", id, b), rdata, data[b]);
            end
         end else begin
            chk($sformatf("txn%0d idle rdata c%0d", id, c), rdata, 64'd0);
         end
         if (c == L + 5) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][63:0] old_line;
      logic [3:0][63:0] new_line;
      logic [3:0][63:0] mix_line;
      logic             exp_r;

      vecs[0] = '{wr: 1'b1, addr: 32'h0000_0040, data: {B4, B3, B2, B1}};
      vecs[1] = '{wr: 1'b0, addr: 32'h0000_0040, data: {B4, B3, B2, B1}};
      vecs[2] = '{wr: 1'b1, addr: 32'h0000_0000, data: {AA, AA, AA, AA}};
      vecs[3] = '{wr: 1'b0, addr: 32'h0000_2000, data: {AA, AA, AA, AA}};
      vecs[4] = '{wr: 1'b1, addr: 32'h0000_0060, data: {C3, C2, C1, C0}};
      vecs[5] = '{wr: 1'b0, addr: 32'h0000_2060, data: {C3, C2, C1, C0}};
      vecs[6] = '{wr: 1'b0, addr: 32'h0000_005F, data: {B4, B3, B2, B1}};

      do_reset();

      // Reset state
      chk("reset resp",   64'(resp),  64'd0);
      chk("reset rdata",  rdata,      64'd0);
      chk("reset err",    64'(err),   64'd0);
      chk("reset resp1",  64'(resp1), 64'd0);
      chk("reset rdata1", rdata1,     64'd0);
      chk("reset err1",   64'(err1),  64'd0);

      // Table: writes, read-backs, aliasing, ignored low address bits
      for (int i = 0; i < 7; i++) begin
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, i);
         chk($sformatf("txn%0d err", i), 64'(err), 64'd0);
      end

      // LATENCY=1, read held across DONE: second acceptance at end of cycle 7
      do_reset();
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_0040;
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         exp_r = ((c >= 2) && (c <= 5)) || ((c >= 9) && (c <= 12));
         chk($sformatf("lat1 resp1 c%0d", c), 64'(resp1), 64'(exp_r));
         if (c == 13) pmem_read = 1'b0;
      end
      chk("lat1 err1", 64'(err1), 64'd0);

      // Both requests high in IDLE for one cycle
      do_reset();
      pmem_read  = 1'b1;
      pmem_write = 1'b1;
      @(posedge clk); #1;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      for (int c = 1; c <= L + 8; c++) begin
         @(posedge clk); #1;
         chk($sformatf("both resp c%0d", c), 64'(resp), 64'd0);
         chk($sformatf("both err c%0d", c), 64'(err), 64'd1);
      end
      chk("both err1", 64'(err1), 64'd1);
      rst = 1'b1;
      #1;
      chk("both err after rst", 64'(err), 64'd0);

      // Reset in the middle of a write burst, during the third beat
      do_reset();
      old_line = {C0, C1, B3, B2};
      new_line = {C3, C2, AA, B4};
      do_txn(1'b1, 32'h0000_0080, old_line, 20);
      pmem_write   = 1'b1;
      pmem_address = 32'h0000_0080;
      for (int c = 1; c <= L + 3; c++) begin
         @(posedge clk); #1;
         if (c >= L + 1) pmem_wdata = new_line[c - L - 1];
      end
      chk("midrst resp before", 64'(resp), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst resp async", 64'(resp), 64'd0);
      chk("midrst rdata", rdata, 64'd0);
      pmem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst resp idle", 64'(resp), 64'd0);
      mix_line    = old_line;
      mix_line[0] = new_line[0];
      mix_line[1] = new_line[1];
      do_txn(1'b0, 32'h0000_0080, mix_line, 21);
      chk("midrst err", 64'(err), 64'd0);

      // Read request dropped during WAIT: full burst still issued, err set
      do_reset();
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_0040;
      for (int c = 1; c <= L + 5; c++) begin
         @(posedge clk); #1;
         exp_r = (c >= L + 1) && (c <= L + 4);
         chk($sformatf("drop resp c%0d", c), 64'(resp), 64'(exp_r));
         if (exp_r) begin
            chk($sformatf("drop rdata beat%0d", c - L - 1), rdata, vecs[1].data[c - L - 1]);
         end
         if (c == 3) pmem_read = 1'b0;
      end
      @(posedge clk); #1;
      chk("drop err", 64'(err), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
